ofmap_writer: RTL and testbench

- Consumer end of the ReLU output interface: takes the 36-bit non-negative ReLU results one at a time over a valid/ready stream.
- Requantizes each result to 16 bits (rounded right shift, then saturate) and buffers it in a 4-entry FIFO.
- Writes each value to output-feature-map SRAM at row-major addresses from a programmed base.
- Signals done once a full map_w x map_h tile has been written.

---
 rtl/ofmap_writer.sv | 116 +++++++++++
 tb/tb_ofmap_writer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_writer.sv
// ofmap_writer: requantizes ReLU results to 16 bits, buffers them in a small FIFO
// and writes them row-major into output-feature-map SRAM from a programmed base.
module ofmap_writer #(
  parameter int DATA_IN_W  = 36,
  parameter int DATA_OUT_W = 16,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [7:0]            map_w,
  input  logic [7:0]            map_h,
  input  logic [4:0]            shift,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_IN_W-1:0]  img_res,
  output logic                  sram_wr_en,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_OUT_W-1:0] sram_wdata,
  input  logic                  sram_gnt,
  output logic                  busy,
  output logic                  done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [DATA_IN_W:0] SAT = (DATA_IN_W+1)'(32767);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [15:0]             total_q, total_d, acc_q, acc_d, wr_q, wr_d, tot_new;
  logic [4:0]              shift_q, shift_d;
  logic [PW-1:0]           rd_q, rd_d, wp_q, wp_d;
  logic [PW:0]             cnt_q, cnt_d;
  logic [DATA_OUT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_IN_W:0]      rnd, sum, r, sat_r;
  logic [DATA_OUT_W-1:0]   word;
  logic                    push, pop, full, empty;

  // Rounded right shift at DATA_IN_W+1 bits so the rounding add never overflows
  always_comb begin
    rnd   = (shift_q == 5'd0) ? '0 : ((DATA_IN_W+1)'(1) << (shift_q - 5'd1));
    sum   = {1'b0, img_res} + rnd;
    r     = sum >> shift_q;
    sat_r = (r > SAT) ? SAT : r;
    word  = sat_r[DATA_OUT_W-1:0];
  end

  assign full       = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign empty      = cnt_q == '0;
  assign in_ready   = (state_q == RUN) && !full && (acc_q < total_q);
  assign push       = in_valid && in_ready;
  assign sram_wr_en = !empty;
  assign pop        = sram_wr_en && sram_gnt;
  assign sram_addr  = base_q + ADDR_W'(wr_q);
  assign sram_wdata = empty ? '0 : mem_q[rd_q];
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign tot_new    = 16'(map_w) * 16'(map_h);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    total_d = total_q;
    shift_d = shift_q;
    acc_d   = acc_q + 16'(push);
    wr_d    = wr_q + 16'(pop);
    rd_d    = rd_q + PW'(pop);
    wp_d    = wp_q + PW'(push);
    cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    case (state_q)
      IDLE: if (start) begin
        base_d  = base_addr;
        total_d = tot_new;
        shift_d = shift;
        acc_d   = '0;
        wr_d    = '0;
        state_d = (tot_new == 16'd0) ? DONE : RUN;
      end
      RUN:   state_d = (acc_d == total_q) ? DRAIN : RUN;
      DRAIN: state_d = (cnt_d == '0 && wr_d == total_q) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      total_q <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      total_q <= total_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= word;
  end
endmodule

// File: tb/tb_ofmap_writer.sv
// tb_ofmap_writer: directed checks of requantization, ordering, backpressure,
// zero-size tiles, address wrap and reset abort for ofmap_writer.
module tb_ofmap_writer;
  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, sram_gnt = 0;
  logic [15:0] base_addr = 0;
  logic [7:0]  map_w = 0, map_h = 0;
  logic [4:0]  shift = 0;
  logic [35:0] img_res = 0;
  logic        in_ready, sram_wr_en, busy, done;
  logic [15:0] sram_addr, sram_wdata;
  int          pass_n = 0, total_n = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
  int          n0, d0;
  logic        stable;
  logic [15:0] wa[$], wd[$];
  int          wc[$];

  ofmap_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .map_w(map_w), .map_h(map_h), .shift(shift), .in_valid(in_valid),
    .in_ready(in_ready), .img_res(img_res), .sram_wr_en(sram_wr_en),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_gnt(sram_gnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // Mid-cycle log of every granted write and every done pulse
  always @(negedge clk) begin
    if (sram_wr_en && sram_gnt) begin
      wa.push_back(sram_addr);
      wd.push_back(sram_wdata);
      wc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [15:0] b, input logic [7:0] w, input logic [7:0] h,
                            input logic [4:0] s);
    base_addr = b; map_w = w; map_h = h; shift = s; start = 1;
    tick();
    start = 0;
  endtask

  task automatic send(input logic [35:0] v);
    logic ok = 0;
    in_valid = 1;
    img_res  = v;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    chk("send_accept", ok, 1);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 200 && done_cnt == n; i++) tick();
    chk("done_seen", done_cnt, n + 1);
  endtask

  task automatic chk_wr(input int idx, input logic [15:0] a, input logic [15:0] d);
    chk("wr_addr", wa[idx], a);
    chk("wr_data", wd[idx], d);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_outputs", {in_ready, sram_wr_en, sram_addr, sram_wdata, busy, done}, 0);
    rst_n = 1;
    tick();

    // Basic 2x2 tile, saturation of 40000
    sram_gnt = 1;
    n0 = wa.size(); d0 = done_cnt;
    start_tile(16'h0100, 2, 2, 0);
    chk("busy_run", busy, 1);
    send(5); send(0); send(40000); send(7);
    in_valid = 0;
    wait_done(d0);
    chk("busy_after_done", {busy, done}, 0);
    chk("basic_n", wa.size() - n0, 4);
    chk_wr(n0, 16'h0100, 5);
    chk_wr(n0 + 1, 16'h0101, 0);
    chk_wr(n0 + 2, 16'h0102, 32767);
    chk_wr(n0 + 3, 16'h0103, 7);
    chk("done_timing", done_cyc, wc[n0 + 3] + 1);
    repeat (3) tick();
    chk("done_once", done_cnt, d0 + 1);

    // Rounding with shift 4 and the largest 36-bit input
    n0 = wa.size(); d0 = done_cnt;
    start_tile(16'h0200, 5, 1, 4);
    send(23); send(24); send(8); send(7); send(36'h7_FFFF_FFFF);
    in_valid = 0;
    wait_done(d0);
    chk("round_n", wa.size() - n0, 5);
    chk_wr(n0, 16'h0200, 1);
    chk_wr(n0 + 1, 16'h0201, 2);
    chk_wr(n0 + 2, 16'h0202, 1);
    chk_wr(n0 + 3, 16'h0203, 0);
    chk_wr(n0 + 4, 16'h0204, 32767);

    // Backpressure: grant withheld while the stream keeps coming
    sram_gnt = 0;
    n0 = wa.size(); d0 = done_cnt;
    start_tile(16'h0300, 8, 1, 0);
    send(100); send(101); send(102); send(103);
    img_res = 104;
    chk("full_not_ready", in_ready, 0);
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      stable &= !in_ready && sram_wr_en && sram_addr == 16'h0300 && sram_wdata == 16'd100;
      tick();
    end
    chk("stall_stable", stable, 1);
    chk("stall_no_write", wa.size() - n0, 0);
    sram_gnt = 1;
    send(104); send(105); send(106); send(107);
    in_valid = 0;
    wait_done(d0);
    chk("bp_n", wa.size() - n0, 8);
    for (int i = 0; i < 8; i++) chk_wr(n0 + i, 16'h0300 + 16'(i), 16'd100 + 16'(i));

    // Zero-size tile
    n0 = wa.size(); d0 = done_cnt;
    start_tile(16'h0700, 0, 5, 0);
    chk("zero_done", {busy, done}, 2'b11);
    tick();
    chk("zero_idle", {busy, done}, 0);
    repeat (3) tick();
    chk("zero_no_write", wa.size() - n0, 0);
    chk("zero_done_once", done_cnt, d0 + 1);

    // Start pulse mid-tile is ignored
    n0 = wa.size(); d0 = done_cnt;
    start_tile(16'h0400, 2, 2, 0);
    send(11); send(12);
    in_valid = 0;
    start_tile(16'h0900, 1, 1, 3);
    send(13); send(14);
    in_valid = 0;
    wait_done(d0);
    chk("ign_n", wa.size() - n0, 4);
    for (int i = 0; i < 4; i++) chk_wr(n0 + i, 16'h0400 + 16'(i), 16'd11 + 16'(i));

    // Address wrap
    n0 = wa.size(); d0 = done_cnt;
    start_tile(16'hFFFE, 2, 2, 0);
    send(1); send(2); send(3); send(4);
    in_valid = 0;
    wait_done(d0);
    chk_wr(n0, 16'hFFFE, 1);
    chk_wr(n0 + 1, 16'hFFFF, 2);
    chk_wr(n0 + 2, 16'h0000, 3);
    chk_wr(n0 + 3, 16'h0001, 4);

    // Reset abort after two writes, one word still buffered
    n0 = wa.size(); d0 = done_cnt;
    start_tile(16'h0500, 4, 1, 0);
    send(21); send(22); send(23);
    in_valid = 0;
    sram_gnt = 0;
    for (int i = 0; i < 50 && wa.size() - n0 < 2; i++) tick();
    chk("abort_pre_n", wa.size() - n0, 2);
    chk("abort_pending", sram_wr_en, 1);
    rst_n = 0;
    #1;
    chk("abort_outputs", {in_ready, sram_wr_en, sram_addr, sram_wdata, busy, done}, 0);
    sram_gnt = 1;
    repeat (3) tick();
    chk("abort_quiet", {sram_wr_en, busy, done}, 0);
    rst_n = 1;
    tick();
    chk("abort_no_done", done_cnt, d0);
    chk("abort_no_write", wa.size() - n0, 2);
    start_tile(16'h0600, 1, 2, 0);
    send(9); send(10);
    in_valid = 0;
    wait_done(d0);
    chk("restart_n", wa.size() - n0, 4);
    chk_wr(n0 + 2, 16'h0600, 9);
    chk_wr(n0 + 3, 16'h0601, 10);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
